// File: rtl/commit_ctrl_pkg.sv
// Shared widths, flush window length and state encoding for the commit controller.
// Widths track the ROB / register-file / datapath widths of the core.
package commit_ctrl_pkg;

    localparam int ROB_POS_WID         = 4;
    localparam int REG_POS_WID         = 5;
    localparam int DATA_WID            = 32;
    localparam int COMMIT_FLUSH_CYCLES = 2;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ST_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

endpackage

// File: rtl/commit_ctrl.sv
// In-order retirement sequencer: pops finished ROB heads, drives the RegFile
// commit port, runs the store handshake with the LSB and raises rollbacks.
module commit_ctrl
    import commit_ctrl_pkg::*;
#(
    parameter int ROB_POS_W    = ROB_POS_WID,
    parameter int REG_POS_W    = REG_POS_WID,
    parameter int DATA_W       = DATA_WID,
    parameter int FLUSH_CYCLES = COMMIT_FLUSH_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 head_valid,
    input  logic                 head_done,
    input  logic [REG_POS_W-1:0] head_rd,
    input  logic [DATA_W-1:0]    head_val,
    input  logic [ROB_POS_W-1:0] head_rob_pos,
    input  logic                 head_is_store,
    input  logic                 head_mispred,
    input  logic [DATA_W-1:0]    head_target,
    output logic                 rob_pop,
    output logic                 commit,
    output logic [REG_POS_W-1:0] commit_rd,
    output logic [DATA_W-1:0]    commit_val,
    output logic [ROB_POS_W-1:0] commit_rob_pos,
    output logic                 store_go,
    input  logic                 store_done,
    output logic                 rollback,
    output logic [DATA_W-1:0]    redirect_pc,
    output logic [31:0]          commit_cnt
);

    localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] flush_cnt;
    logic             run_retire;
    logic             store_issue;
    logic             store_retire;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        run_retire   = 1'b0;
        store_issue  = 1'b0;
        store_retire = 1'b0;
        if (!rst && rdy) begin
            run_retire   = (state == RUN) && head_valid && head_done && !head_is_store;
            store_issue  = (state == RUN) && head_valid && head_done && head_is_store;
            store_retire = (state == ST_WAIT) && store_done;
        end
        rob_pop = run_retire || store_retire;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            flush_cnt      <= '0;
            commit         <= 1'b0;
            commit_rd      <= '0;
            commit_val     <= '0;
            commit_rob_pos <= '0;
            store_go       <= 1'b0;
            rollback       <= 1'b0;
            redirect_pc    <= '0;
            commit_cnt     <= '0;
        end else if (rdy) begin
            // Pulses are recomputed every rdy edge, so each lasts exactly one rdy cycle.
            commit   <= run_retire;
            store_go <= store_issue;
            rollback <= run_retire && head_mispred;

            if (run_retire) begin
                commit_rd      <= head_rd;
                commit_val     <= head_val;
                commit_rob_pos <= head_rob_pos;
            end
            if (run_retire && head_mispred) begin
                redirect_pc <= head_target;
            end
            if (rob_pop) begin
                commit_cnt <= commit_cnt + 32'd1;
            end

            case (state)
                RUN: begin
                    if (run_retire && head_mispred) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_INIT;
                    end else if (store_issue) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (store_retire) begin
                        state <= RUN;
                    end
                end
                FLUSH: begin
                    // The last decrement lands on zero and reopens retirement together.
                    if (flush_cnt <= CNT_W'(1)) begin
                        flush_cnt <= '0;
                        state     <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= RUN;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl: retirement, store handshake, rollback/flush,
// rdy stalls, reset in non-RUN states and a not-done head.
module tb_commit_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        head_valid;
    logic        head_done;
    logic [4:0]  head_rd;
    logic [31:0] head_val;
    logic [3:0]  head_rob_pos;
    logic        head_is_store;
    logic        head_mispred;
    logic [31:0] head_target;
    logic        rob_pop;
    logic        commit;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_rob_pos;
    logic        store_go;
    logic        store_done;
    logic        rollback;
    logic [31:0] redirect_pc;
    logic [31:0] commit_cnt;

    int checks;
    int failures;

    commit_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .head_valid    (head_valid),
        .head_done     (head_done),
        .head_rd       (head_rd),
        .head_val      (head_val),
        .head_rob_pos  (head_rob_pos),
        .head_is_store (head_is_store),
        .head_mispred  (head_mispred),
        .head_target   (head_target),
        .rob_pop       (rob_pop),
        .commit        (commit),
        .commit_rd     (commit_rd),
        .commit_val    (commit_val),
        .commit_rob_pos(commit_rob_pos),
        .store_go      (store_go),
        .store_done    (store_done),
        .rollback      (rollback),
        .redirect_pc   (redirect_pc),
        .commit_cnt    (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input logic v, input logic d, input logic [4:0] rd,
                            input logic [31:0] val, input logic [3:0] pos,
                            input logic st, input logic mp, input logic [31:0] tgt);
        head_valid    = v;
        head_done     = d;
        head_rd       = rd;
        head_val      = val;
        head_rob_pos  = pos;
        head_is_store = st;
        head_mispred  = mp;
        head_target   = tgt;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdy = 1'b1;
        store_done = 1'b0;
        set_head(1'b1, 1'b1, 5'd3, 32'hAA, 4'd1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (rob_pop !== 1'b0) begin
            failures++; $display("FAIL reset_pop got=%b want=0", rob_pop);
        end
        step(); step();
        checks++;
        if ({commit, store_go, rollback, commit_rd, commit_val, commit_rob_pos, redirect_pc, commit_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got commit=%b sg=%b rb=%b rd=%0d val=%h pos=%0d pc=%h cnt=%0d want all 0",
                     commit, store_go, rollback, commit_rd, commit_val, commit_rob_pos, redirect_pc, commit_cnt);
        end
        rst = 1'b0;
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b0, 32'h0);
        step();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds  [3] = '{5'd5, 5'd6, 5'd0};
        logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) begin
            set_head(1'b1, 1'b1, rds[i], vals[i], 4'(i + 2), 1'b0, 1'b0, 32'h0);
            checks++;
            if (rob_pop !== 1'b1) begin
                failures++; $display("FAIL b2b_pop[%0d] got=%b want=1", i, rob_pop);
            end
            step();
            checks++;
            if (commit !== 1'b1 || commit_rd !== rds[i] || commit_val !== vals[i] ||
                commit_rob_pos !== 4'(i + 2) || commit_cnt !== 32'(i + 1)) begin
                failures++;
                $display("FAIL b2b_commit[%0d] got c=%b rd=%0d val=%h pos=%0d cnt=%0d want c=1 rd=%0d val=%h pos=%0d cnt=%0d",
                         i, commit, commit_rd, commit_val, commit_rob_pos, commit_cnt, rds[i], vals[i], i + 2, i + 1);
            end
        end
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (rob_pop !== 1'b0) begin
            failures++; $display("FAIL b2b_empty_pop got=%b want=0", rob_pop);
        end
        step();
        checks++;
        if (commit !== 1'b0 || commit_cnt !== 32'd3) begin
            failures++; $display("FAIL b2b_end got c=%b cnt=%0d want c=0 cnt=3", commit, commit_cnt);
        end
    endtask

    task automatic test_store();
        // store_done while in RUN is ignored
        store_done = 1'b1;
        #1;
        checks++;
        if (rob_pop !== 1'b0) begin
            failures++; $display("FAIL store_run_ignore_pop got=%b want=0", rob_pop);
        end
        step();
        store_done = 1'b0;
        set_head(1'b1, 1'b1, 5'd0, 32'h0, 4'd5, 1'b1, 1'b0, 32'h0);
        checks++;
        if (rob_pop !== 1'b0) begin
            failures++; $display("FAIL store_issue_pop got=%b want=0", rob_pop);
        end
        step();
        checks++;
        if (store_go !== 1'b1 || commit !== 1'b0 || commit_cnt !== 32'd3) begin
            failures++; $display("FAIL store_go_pulse got sg=%b c=%b cnt=%0d want sg=1 c=0 cnt=3", store_go, commit, commit_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (store_go !== 1'b0 || rob_pop !== 1'b0) begin
                failures++; $display("FAIL store_wait[%0d] got sg=%b pop=%b want sg=0 pop=0", i, store_go, rob_pop);
            end
        end
        store_done = 1'b1;
        #1;
        checks++;
        if (rob_pop !== 1'b1) begin
            failures++; $display("FAIL store_done_pop got=%b want=1", rob_pop);
        end
        step();
        store_done = 1'b0;
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (commit !== 1'b0 || store_go !== 1'b0 || commit_cnt !== 32'd4) begin
            failures++; $display("FAIL store_retire got c=%b sg=%b cnt=%0d want c=0 sg=0 cnt=4", commit, store_go, commit_cnt);
        end
    endtask

    task automatic test_mispredict();
        set_head(1'b1, 1'b1, 5'd1, 32'h1004, 4'd6, 1'b0, 1'b1, 32'h2000);
        checks++;
        if (rob_pop !== 1'b1) begin
            failures++; $display("FAIL mp_pop got=%b want=1", rob_pop);
        end
        step();
        checks++;
        if (commit !== 1'b1 || rollback !== 1'b1 || commit_rd !== 5'd1 || commit_val !== 32'h1004 ||
            redirect_pc !== 32'h2000 || commit_cnt !== 32'd5) begin
            failures++;
            $display("FAIL mp_commit got c=%b rb=%b rd=%0d val=%h pc=%h cnt=%0d want c=1 rb=1 rd=1 val=1004 pc=2000 cnt=5",
                     commit, rollback, commit_rd, commit_val, redirect_pc, commit_cnt);
        end
        set_head(1'b1, 1'b1, 5'd7, 32'h77, 4'd7, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rob_pop !== 1'b0) begin
                failures++; $display("FAIL mp_flush_pop[%0d] got=%b want=0", i, rob_pop);
            end
            step();
            checks++;
            if (commit !== 1'b0 || rollback !== 1'b0) begin
                failures++; $display("FAIL mp_flush_pulse[%0d] got c=%b rb=%b want 0 0", i, commit, rollback);
            end
        end
        checks++;
        if (rob_pop !== 1'b1) begin
            failures++; $display("FAIL mp_resume_pop got=%b want=1", rob_pop);
        end
        step();
        checks++;
        if (commit !== 1'b1 || commit_rd !== 5'd7 || commit_val !== 32'h77 || commit_cnt !== 32'd6) begin
            failures++; $display("FAIL mp_resume_commit got c=%b rd=%0d val=%h cnt=%0d want c=1 rd=7 val=77 cnt=6",
                                 commit, commit_rd, commit_val, commit_cnt);
        end
    endtask

    task automatic test_rdy_stall();
        rdy = 1'b0;
        set_head(1'b1, 1'b1, 5'd8, 32'h88, 4'd8, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rob_pop !== 1'b0) begin
                failures++; $display("FAIL stall_pop[%0d] got=%b want=0", i, rob_pop);
            end
            step();
            checks++;
            if (commit !== 1'b1 || commit_rd !== 5'd7 || commit_val !== 32'h77 || commit_cnt !== 32'd6) begin
                failures++; $display("FAIL stall_hold[%0d] got c=%b rd=%0d val=%h cnt=%0d want c=1 rd=7 val=77 cnt=6",
                                     i, commit, commit_rd, commit_val, commit_cnt);
            end
        end
        rdy = 1'b1;
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (rob_pop !== 1'b0) begin
            failures++; $display("FAIL stall_release_pop got=%b want=0", rob_pop);
        end
        step();
        checks++;
        if (commit !== 1'b0 || commit_cnt !== 32'd6) begin
            failures++; $display("FAIL stall_release got c=%b cnt=%0d want c=0 cnt=6", commit, commit_cnt);
        end
    endtask

    task automatic test_reset_states();
        // Reset while in ST_WAIT
        set_head(1'b1, 1'b1, 5'd0, 32'h0, 4'd9, 1'b1, 1'b0, 32'h0);
        step();
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        store_done = 1'b1;
        #1;
        checks++;
        if (rob_pop !== 1'b0) begin
            failures++; $display("FAIL rst_stwait_pop got=%b want=0", rob_pop);
        end
        step();
        rst = 1'b0;
        store_done = 1'b0;
        checks++;
        if ({commit, store_go, rollback, commit_rd, commit_val, commit_rob_pos, redirect_pc, commit_cnt} !== '0) begin
            failures++; $display("FAIL rst_stwait_out got c=%b sg=%b rb=%b cnt=%0d want all 0", commit, store_go, rollback, commit_cnt);
        end
        // Back in RUN: a new store head must issue store_go again
        set_head(1'b1, 1'b1, 5'd0, 32'h0, 4'd10, 1'b1, 1'b0, 32'h0);
        step();
        checks++;
        if (store_go !== 1'b1) begin
            failures++; $display("FAIL rst_stwait_run got sg=%b want=1", store_go);
        end
        store_done = 1'b1;
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b0, 32'h0);
        step();
        store_done = 1'b0;
        // Reset while in FLUSH
        set_head(1'b1, 1'b1, 5'd2, 32'h55, 4'd11, 1'b0, 1'b1, 32'h3000);
        step();
        checks++;
        if (rollback !== 1'b1 || commit_cnt !== 32'd2) begin
            failures++; $display("FAIL rst_flush_setup got rb=%b cnt=%0d want rb=1 cnt=2", rollback, commit_cnt);
        end
        rst = 1'b1;
        set_head(1'b1, 1'b1, 5'd4, 32'h44, 4'd12, 1'b0, 1'b0, 32'h0);
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({commit, store_go, rollback, commit_rd, commit_val, commit_rob_pos, redirect_pc, commit_cnt} !== '0) begin
            failures++; $display("FAIL rst_flush_out got c=%b sg=%b rb=%b pc=%h cnt=%0d want all 0", commit, store_go, rollback, redirect_pc, commit_cnt);
        end
        checks++;
        if (rob_pop !== 1'b1) begin
            failures++; $display("FAIL rst_flush_run_pop got=%b want=1", rob_pop);
        end
        step();
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b0, 32'h0);
        step();
    endtask

    task automatic test_not_done();
        set_head(1'b1, 1'b0, 5'd9, 32'h99, 4'd13, 1'b0, 1'b1, 32'h4000);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rob_pop !== 1'b0) begin
                failures++; $display("FAIL notdone_pop[%0d] got=%b want=0", i, rob_pop);
            end
            step();
            checks++;
            if (commit !== 1'b0 || store_go !== 1'b0 || rollback !== 1'b0 || commit_cnt !== 32'd1) begin
                failures++; $display("FAIL notdone_pulse[%0d] got c=%b sg=%b rb=%b cnt=%0d want 0 0 0 cnt=1",
                                     i, commit, store_go, rollback, commit_cnt);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_back_to_back();
        test_store();
        test_mispredict();
        test_rdy_stall();
        test_reset_states();
        test_not_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
